melody_player_ctrl: RTL and testbench

Playback controller for the tone generator. It sequences the note index that feeds the notes ROM, and times each note's length in beat strobes from the strobe generator. It inserts an articulation gap between notes and gates the PWM output through tone_en_o. It replaces the free-running sequence counter and adds start, stop, pause and loop control.

---
 rtl/melody_player_ctrl.sv | 152 +++++++++++++++
 tb/tb_melody_player_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player_ctrl.sv
// Melody playback sequencer: steps the notes-ROM address, times each note in beat
// strobes, inserts articulation gaps and handles start/stop/pause/loop control.
module melody_player_ctrl #(
  parameter int IDX_BW    = 6,
  parameter int SEQ_LEN   = 64,
  parameter int DUR_BW    = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strb_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              loop_i,
  input  logic [IDX_BW-1:0] last_idx_i,
  input  logic [DUR_BW-1:0] note_dur_i,
  output logic [IDX_BW-1:0] note_index_o,
  output logic              tone_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_GAP    = 3'd3,
    S_PAUSED = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int                GAP_BW    = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [GAP_BW-1:0] GAP_INIT  = GAP_BW'(GAP_TICKS);
  localparam logic [IDX_BW-1:0] IDX_MAX   = IDX_BW'(SEQ_LEN - 1);
  localparam logic [IDX_BW:0]   SEQ_LEN_X = (IDX_BW + 1)'(SEQ_LEN);

  state_t              state_q, state_d, saved_q, saved_d;
  logic [IDX_BW-1:0]   idx_d;
  logic [DUR_BW-1:0]   dur_cnt_q, dur_cnt_d;
  logic [GAP_BW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_BW-1:0]   last_clamped;
  logic [IDX_BW-1:0]   adv_idx;
  state_t              adv_state;

  // Where the sequence goes once the current note (and its gap) has finished.
  always_comb begin
    last_clamped = ({1'b0, last_idx_i} >= SEQ_LEN_X) ? IDX_MAX : last_idx_i;
    adv_idx      = note_index_o;
    adv_state    = S_LOAD;
    if (note_index_o == last_clamped) begin
      if (loop_i) begin
        adv_idx = '0;
      end else begin
        adv_state = S_DONE;
      end
    end else if (note_index_o == IDX_MAX) begin
      adv_idx = '0;
    end else begin
      adv_idx = note_index_o + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    idx_d     = note_index_o;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (stop_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            state_d = S_LOAD;
            idx_d   = '0;
          end
        end
        S_LOAD: begin
          dur_cnt_d = (note_dur_i == '0) ? DUR_BW'(1) : note_dur_i;
          state_d   = S_PLAY;
        end
        S_PLAY: begin
          if (pause_i) begin
            state_d = S_PAUSED;
            saved_d = S_PLAY;
          end else if (strb_i) begin
            if (dur_cnt_q == DUR_BW'(1)) begin
              if (GAP_TICKS > 0) begin
                state_d   = S_GAP;
                gap_cnt_d = GAP_INIT;
              end else begin
                state_d = adv_state;
                idx_d   = adv_idx;
              end
            end else begin
              dur_cnt_d = dur_cnt_q - 1'b1;
            end
          end
        end
        S_GAP: begin
          if (pause_i) begin
            state_d = S_PAUSED;
            saved_d = S_GAP;
          end else if (strb_i) begin
            if (gap_cnt_q == GAP_BW'(1)) begin
              state_d = adv_state;
              idx_d   = adv_idx;
            end else begin
              gap_cnt_d = gap_cnt_q - 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (!pause_i) state_d = saved_q;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Flags are registered from the next state so they line up with state_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      saved_q      <= S_PLAY;
      note_index_o <= '0;
      dur_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tone_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      note_index_o <= idx_d;
      dur_cnt_q    <= dur_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tone_en_o    <= (state_d == S_PLAY);
      busy_o       <= (state_d == S_LOAD) || (state_d == S_PLAY) ||
                      (state_d == S_GAP)  || (state_d == S_PAUSED);
      done_o       <= (state_d == S_DONE);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_melody_player_ctrl.sv
// Scoreboarded bench for melody_player_ctrl: expected per-note tone/gap strobe
// counts are queued at start and popped as the DUT finishes each note.
module tb_melody_player_ctrl;

  typedef struct {
    int idx;
    int tone;
    int gap;
  } note_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       strb_i = 1'b0;
  logic       start_i = 1'b0, stop_i = 1'b0, pause_i = 1'b0, loop_i = 1'b0;
  logic [5:0] last_idx_i = '0;
  logic [3:0] note_dur_i;
  logic [5:0] note_index_o;
  logic       tone_en_o, busy_o, done_o;
  logic [2:0] state_o;
  logic [3:0] dur_rom [64];

  logic       start2 = 1'b0;
  logic [6:0] idx2;
  logic       tone2, busy2, done2;
  logic [2:0] st2;

  int pass_cnt = 0, check_cnt = 0;
  note_t exp_q[$];
  bit  mon_en = 1'b0;
  int  cur_tone = 0, cur_gap = 0, done_cnt = 0, notes_done = 0;
  logic [2:0] prev_st = 3'd0;
  logic [5:0] prev_idx = '0;
  int  gap_seen2 = 0, loads2 = 0, done_cnt2 = 0, done_idx2 = -1;
  logic [2:0] prev_st2 = 3'd0;
  logic [2:0] scnt = 3'd0;

  assign note_dur_i = dur_rom[note_index_o];

  melody_player_ctrl #(.IDX_BW(6), .SEQ_LEN(64), .DUR_BW(4), .GAP_TICKS(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .strb_i(strb_i), .start_i(start_i), .stop_i(stop_i),
    .pause_i(pause_i), .loop_i(loop_i), .last_idx_i(last_idx_i), .note_dur_i(note_dur_i),
    .note_index_o(note_index_o), .tone_en_o(tone_en_o), .busy_o(busy_o),
    .done_o(done_o), .state_o(state_o)
  );

  // Legato build with a wider index so an out-of-range last index can be driven.
  melody_player_ctrl #(.IDX_BW(7), .SEQ_LEN(64), .DUR_BW(4), .GAP_TICKS(0)) dut_legato (
    .clk_i(clk), .rst_i(rst_i), .strb_i(strb_i), .start_i(start2), .stop_i(1'b0),
    .pause_i(1'b0), .loop_i(1'b0), .last_idx_i(7'd70), .note_dur_i(4'd1),
    .note_index_o(idx2), .tone_en_o(tone2), .busy_o(busy2),
    .done_o(done2), .state_o(st2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    strb_i = (scnt == 3'd7);
    scnt   = scnt + 3'd1;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [5:0] last, input logic lp);
    last_idx_i = last;
    loop_i     = lp;
    done_cnt   = 0;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
  endtask

  task automatic wait_note(input string tag, input int idx, input int st, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state_o == 3'(st) && note_index_o == 6'(idx)) return;
      step();
    end
    checkOutput(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state_o == 3'd0) return;
      step();
    end
    checkOutput(tag, 0, 1);
  endtask

  // Per-note monitor: strobes heard while audible and while in the gap.
  always @(negedge clk) begin
    note_t e;
    if (tone_en_o && strb_i) cur_tone++;
    if (state_o == 3'd3 && strb_i) cur_gap++;
    if (done_o) begin
      done_cnt++;
      checkOutput("done_busy", int'(busy_o), 0);
    end
    if (mon_en && (prev_st inside {3'd2, 3'd3, 3'd4}) && (state_o inside {3'd0, 3'd1, 3'd5})) begin
      notes_done++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("note_idx", int'(prev_idx), e.idx);
        checkOutput("note_tone_strobes", cur_tone, e.tone);
        checkOutput("note_gap_strobes", cur_gap, e.gap);
      end
    end
    if (state_o == 3'd1) begin
      cur_tone = 0;
      cur_gap  = 0;
    end
    prev_st  = state_o;
    prev_idx = note_index_o;
  end

  always @(negedge clk) begin
    if (st2 == 3'd3) gap_seen2++;
    if (st2 == 3'd1 && prev_st2 != 3'd1) loads2++;
    if (done2) begin
      done_cnt2++;
      done_idx2 = int'(idx2);
    end
    prev_st2 = st2;
  end

  initial begin
    for (int i = 0; i < 64; i++) dur_rom[i] = 4'd1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_state", int'(state_o), 0);
    checkOutput("rst_idx", int'(note_index_o), 0);
    checkOutput("rst_tone", int'(tone_en_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    rst_i = 1'b0;
    step();
    mon_en = 1'b1;

    // Basic three-note sequence with 2-cycle start latency.
    dur_rom[0] = 4'd2; dur_rom[1] = 4'd1; dur_rom[2] = 4'd3;
    exp_q.push_back('{0, 2, 1}); exp_q.push_back('{1, 1, 1}); exp_q.push_back('{2, 3, 1});
    applyStimulus(6'd2, 1'b0);
    checkOutput("lat_load_state", int'(state_o), 1);
    checkOutput("lat_load_tone", int'(tone_en_o), 0);
    step();
    checkOutput("lat_play_state", int'(state_o), 2);
    checkOutput("lat_play_tone", int'(tone_en_o), 1);
    wait_idle("timeout_basic", 400);
    checkOutput("basic_done_cnt", done_cnt, 1);
    checkOutput("basic_busy", int'(busy_o), 0);
    checkOutput("basic_idx_hold", int'(note_index_o), 2);
    checkOutput("basic_sb_empty", exp_q.size(), 0);

    // Loop back to index 0, then drop loop during the second pass.
    exp_q.push_back('{0, 2, 1}); exp_q.push_back('{1, 1, 1}); exp_q.push_back('{2, 3, 1});
    exp_q.push_back('{0, 2, 1}); exp_q.push_back('{1, 1, 1}); exp_q.push_back('{2, 3, 1});
    applyStimulus(6'd2, 1'b1);
    wait_note("timeout_loop_n2", 2, 2, 400);
    wait_note("timeout_loop_n1", 1, 2, 400);
    checkOutput("loop_no_done", done_cnt, 0);
    loop_i = 1'b0;
    wait_idle("timeout_loop", 600);
    checkOutput("loop_done_cnt", done_cnt, 1);
    checkOutput("loop_sb_empty", exp_q.size(), 0);

    // Pause a duration-3 note after its first strobe.
    dur_rom[0] = 4'd3;
    exp_q.push_back('{0, 3, 1});
    applyStimulus(6'd0, 1'b0);
    wait_note("timeout_pause_play", 0, 2, 20);
    for (int i = 0; i < 40 && cur_tone < 1; i++) step();
    checkOutput("pause_pre_strobes", cur_tone, 1);
    pause_i = 1'b1;
    step();
    checkOutput("pause_state", int'(state_o), 4);
    checkOutput("pause_tone", int'(tone_en_o), 0);
    repeat (40) step();
    checkOutput("pause_hold_state", int'(state_o), 4);
    checkOutput("pause_hold_busy", int'(busy_o), 1);
    pause_i = 1'b0;
    step();
    checkOutput("pause_resume_tone", int'(tone_en_o), 1);
    wait_idle("timeout_pause", 300);
    checkOutput("pause_done_cnt", done_cnt, 1);
    checkOutput("pause_sb_empty", exp_q.size(), 0);

    // Stop while in the gap after note 1.
    dur_rom[0] = 4'd2;
    exp_q.push_back('{0, 2, 1}); exp_q.push_back('{1, 1, 0});
    applyStimulus(6'd2, 1'b0);
    wait_note("timeout_stop_gap", 1, 3, 300);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checkOutput("stop_state", int'(state_o), 0);
    checkOutput("stop_idx", int'(note_index_o), 0);
    checkOutput("stop_tone", int'(tone_en_o), 0);
    checkOutput("stop_busy", int'(busy_o), 0);
    repeat (50) step();
    checkOutput("stop_no_done", done_cnt, 0);
    checkOutput("stop_sb_empty", exp_q.size(), 0);
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    checkOutput("start_stop_idle", int'(state_o), 0);
    step();
    checkOutput("start_stop_busy", int'(busy_o), 0);

    // Zero duration plays one strobe; last index 0 ends after one note.
    dur_rom[0] = 4'd0;
    exp_q.push_back('{0, 1, 1});
    applyStimulus(6'd0, 1'b0);
    wait_idle("timeout_dur0", 200);
    checkOutput("dur0_done_cnt", done_cnt, 1);
    checkOutput("dur0_sb_empty", exp_q.size(), 0);

    // Legato build with clamped last index: 64 notes, no gaps, done at 63.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 1500 && st2 != 3'd0; i++) step();
    checkOutput("legato_idle", int'(st2), 0);
    checkOutput("legato_loads", loads2, 64);
    checkOutput("legato_no_gap", gap_seen2, 0);
    checkOutput("legato_done_cnt", done_cnt2, 1);
    checkOutput("clamp_done_idx", done_idx2, 63);

    // Asynchronous reset in the middle of a note, then replay.
    dur_rom[0] = 4'd3;
    applyStimulus(6'd2, 1'b0);
    wait_note("timeout_rst_play", 0, 2, 20);
    mon_en = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    checkOutput("arst_state", int'(state_o), 0);
    checkOutput("arst_tone", int'(tone_en_o), 0);
    checkOutput("arst_busy", int'(busy_o), 0);
    checkOutput("arst_idx", int'(note_index_o), 0);
    #3 rst_i = 1'b0;
    step();
    exp_q.delete();
    mon_en = 1'b1;
    exp_q.push_back('{0, 3, 1}); exp_q.push_back('{1, 1, 1}); exp_q.push_back('{2, 3, 1});
    applyStimulus(6'd2, 1'b0);
    step();
    checkOutput("replay_idx0", int'(note_index_o), 0);
    checkOutput("replay_tone", int'(tone_en_o), 1);
    wait_idle("timeout_replay", 400);
    checkOutput("replay_done_cnt", done_cnt, 1);
    checkOutput("replay_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
